// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: load/store modes, FSM states
// and big-endian byte offsets.
package mem_pkg;

  typedef logic [1:0] mem_mode_t;
  typedef logic [2:0] mem_state_t;

  localparam mem_mode_t MODE_WORD  = 2'b00;
  localparam mem_mode_t MODE_SBYTE = 2'b01;
  localparam mem_mode_t MODE_UBYTE = 2'b10;
  localparam mem_mode_t MODE_RSVD  = 2'b11;

  localparam mem_state_t ST_IDLE      = 3'd0;
  localparam mem_state_t ST_READ      = 3'd1;
  localparam mem_state_t ST_RMW_READ  = 3'd2;
  localparam mem_state_t ST_RMW_WRITE = 3'd3;
  localparam mem_state_t ST_RESP      = 3'd4;

  // Big-endian: offset 0 is the most significant byte.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  // Reserved mode behaves as word, so only the two byte modes are "byte".
  function automatic logic is_byte_mode(input mem_mode_t mode);
    return (mode == MODE_SBYTE) || (mode == MODE_UBYTE);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte lane: extracts and extends a load byte, and merges a
// store byte into a read word for read-modify-write.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  mode,
  input  logic [7:0]  byte_in,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = '0;
    merged   = word;
    case (offset)
      OFF_B0: begin sel_byte = word[31:24]; merged[31:24] = byte_in; end
      OFF_B1: begin sel_byte = word[23:16]; merged[23:16] = byte_in; end
      OFF_B2: begin sel_byte = word[15:8];  merged[15:8]  = byte_in; end
      OFF_B3: begin sel_byte = word[7:0];   merged[7:0]   = byte_in; end
      default: ;
    endcase

    load_data = word;
    if (mode == MODE_SBYTE)
      load_data = {{24{sel_byte[7]}}, sel_byte};
    else if (mode == MODE_UBYTE)
      load_data = {24'b0, sel_byte};
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a CPU controller and a synchronous word RAM,
// handling byte loads with extension and byte stores via read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        mode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              misalign,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mem_state_t        state;
  mem_mode_t         mode_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wbyte_q;
  logic              mis_q;
  logic [31:0]       merge_q;

  logic [31:0] load_data;
  logic [31:0] merged;

  // Upper address bits wrap within the RAM depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  byte_lane_unit u_lane (
    .word      (ram_rdata),
    .offset    (off_q),
    .mode      (mode_q),
    .byte_in   (wbyte_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // The acceptance cycle drives the RAM straight from the live inputs so a
  // read issued here returns data in the following state.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = waddr_q;
    ram_wdata = merge_q;
    case (state)
      ST_IDLE: begin
        if (req) begin
          ram_en    = 1'b1;
          ram_we    = we && !is_byte_mode(mode);
          ram_addr  = addr[ADDR_W+1:2];
          ram_wdata = wdata;
        end
      end
      ST_RMW_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      rdata   <= '0;
      merge_q <= '0;
      mis_q   <= 1'b0;
      mode_q  <= MODE_WORD;
      off_q   <= '0;
      waddr_q <= '0;
      wbyte_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            mode_q  <= mode;
            off_q   <= addr[1:0];
            waddr_q <= addr[ADDR_W+1:2];
            wbyte_q <= wdata[7:0];
            mis_q   <= !is_byte_mode(mode) && (addr[1:0] != 2'b00);
            if (!we)
              state <= ST_READ;
            else if (is_byte_mode(mode))
              state <= ST_RMW_READ;
            else
              state <= ST_RESP;
          end
        end
        ST_READ: begin
          rdata <= load_data;
          state <= ST_RESP;
        end
        ST_RMW_READ: begin
          merge_q <= merged;
          state   <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: state <= ST_RESP;
        ST_RESP:      state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  assign done     = (state == ST_RESP);
  assign busy     = (state != ST_IDLE);
  assign misalign = done && mis_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width (depth 2^ADDR_W words).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  access request from controller; held high until done.
REQ-005 we  input  1  1 = store, 0 = load (controller MemWrite).
REQ-006 mode  input  2  00 word, 01 signed byte, 10 unsigned byte, 11 reserved (treated as word).
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; byte stores use wdata[7:0].
REQ-009 rdata  output  32  formatted load data, registered.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 misalign  output  1  pulses with done when a word access has addr[1:0] != 0.
REQ-013 ram_en, ram_we  output  1 each  synchronous RAM enable / write enable.
REQ-014 ram_addr  output  ADDR_W  word index = addr[ADDR_W+1:2].
REQ-015 ram_wdata  output  32  RAM write data.
REQ-016 ram_rdata  input  32  RAM read data, valid the cycle after ram_en with ram_we=0.

Function
REQ-017 Byte order is big-endian: byte offset 0 = bits 31:24, offset 3 = bits 7:0.
REQ-018 FSM states are IDLE, READ, RMW_READ, RMW_WRITE, RESP.
REQ-019 In IDLE, req=1 accepts the request in cycle N and latches we, mode, addr, wdata.
REQ-020 Acceptance cycle N: a load or byte store drives ram_en=1, ram_we=0; a word store drives ram_en=1, ram_we=1, ram_wdata=wdata. All driven from the live inputs.
REQ-021 Transitions from IDLE: a load goes to READ, a byte store goes to RMW_READ, a word store goes to RESP.
REQ-022 READ (N+1): rdata <= formatted ram_rdata; then RESP.
  - Word: the full word.
  - Signed byte: the selected byte, sign-extended.
  - Unsigned byte: the selected byte, zero-extended.
REQ-023 RMW_READ (N+1): the merged word (ram_rdata with the selected byte replaced by latched wdata[7:0]) is registered; then RMW_WRITE.
REQ-024 RMW_WRITE (N+2): ram_en=1, ram_we=1, ram_wdata = merged word, ram_addr from the latched address; then RESP.
REQ-025 RESP: done=1 for exactly one cycle; then IDLE.
REQ-026 Latency from acceptance cycle N to done:
  - Word store: done at N+1.
  - Any load: done at N+2.
  - Byte store: done at N+3.
REQ-027 req still high in the cycle after done is a new request; back-to-back accesses therefore have one IDLE acceptance cycle between them.
REQ-028 Misaligned word access: the access is performed at the aligned word (addr[1:0] ignored), and misalign=1 together with done.
REQ-029 Outside IDLE, the req, we, mode, addr and wdata inputs are ignored.
REQ-030 rdata holds its value until the next load completes; stores do not change rdata.
REQ-031 ram_en=0 and ram_we=0 in every state/cycle not listed above.
REQ-032 addr bits above ADDR_W+1 are ignored (wrap-around within RAM depth).

Reset
REQ-033 While reset=1: ram_en=0 and ram_we=0 combinationally, so no RAM write occurs in the reset cycle.
REQ-034 After reset: state=IDLE, rdata=0, done=0, busy=0, misalign=0, merge register=0.
REQ-035 Reset mid-operation aborts the access: no done pulse, and any pending RMW write is never issued.

Structure
REQ-036 Shared package mem_pkg holds:
  - the MemMode encodings (MODE_WORD=00, MODE_SBYTE=01, MODE_UBYTE=10);
  - the FSM state encoding;
  - the byte-offset constants.
REQ-037 One combinational sub-module, byte_lane_unit, performs byte extract/extend and byte merge; the FSM and registers stay in mem_access_unit.

Verification
REQ-038 RAM word 4 = 0x11223344. Load word at addr 0x10 -> rdata=0x11223344, done at N+2, misalign=0.
REQ-039 RAM word 4 = 0x11F23344. Signed byte at addr 0x11 -> rdata=0xFFFFFFF2; unsigned byte at addr 0x11 -> rdata=0x000000F2.
REQ-040 RAM word 4 = 0x11223344. Byte store wdata=0xAABBCCDD at addr 0x12 -> RAM word 4 = 0x1122DD44, done at N+3, exactly one ram_we cycle (N+2).
REQ-041 Word store 0xDEADBEEF at addr 0x13 -> RAM word 4 = 0xDEADBEEF, done and misalign high at N+1.
REQ-042 Byte store with reset asserted in cycle N+1 -> no ram_we in any cycle, no done; a subsequent load word returns the original RAM data.
REQ-043 req held high for three consecutive loads -> three done pulses spaced 3 cycles apart, busy low only in the acceptance cycles.
